button_press_classifier: RTL and testbench

Consumes the single-cycle edge pulses and debounced level from the button debouncer and classifies each user gesture as a short press, a double press or a long press. Sits directly downstream of the debouncer in the same clock domain and emits one-cycle event pulses for the application logic (mode select, menu navigation). Timing thresholds are set in milliseconds and converted to cycle counts at elaboration.

---
 rtl/button_press_classifier.sv | 136 +++++++++++++
 tb/tb_button_press_classifier.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_press_classifier: turns debounced press/release pulses into       |
// | one-cycle short / double / long press events.            Revision: 1.0   |
// +--------------------------------------------------------------------------+
module button_press_classifier #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int LONG_MS = 500,
  parameter int GAP_MS  = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_db,
  input  logic       button_rising,
  input  logic       button_falling,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
  localparam int MAX_CYC  = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int CW       = $clog2(MAX_CYC + 1);
  localparam logic [31:0] LONG_LIM = 32'(LONG_CYC - 1);
  localparam logic [31:0] GAP_LIM  = 32'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS1   = 2'd1,
    S_GAP      = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          double_q, double_d;
  logic          long_q, long_d;
  logic          busy_q, busy_d;
  logic [7:0]    count_q, count_d;

  logic rise, fall, long_to, gap_to, unused_db;

  // Level is not used for classification; edges alone drive the gesture.
  assign unused_db = button_db;

  // Simultaneous edges are contradictory and therefore discarded.
  assign rise = button_rising & ~button_falling;
  assign fall = button_falling & ~button_rising;

  // Fire on the edge where the counter steps onto its terminal value so the
  // registered pulse lands exactly LONG_CYC / GAP_CYC cycles after the event.
  assign long_to = (32'(cnt_q) + 32'd1) >= LONG_LIM;
  assign gap_to  = (32'(cnt_q) + 32'd1) >= GAP_LIM;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESS1;
          count_d = count_q + 8'd1;
        end
      end
      S_PRESS1: begin
        if (fall) begin
          state_d = S_GAP;
        end else if (long_to) begin
          long_d  = 1'b1;
          state_d = S_WAIT_REL;
        end
      end
      S_GAP: begin
        if (rise) begin
          double_d = 1'b1;
          state_d  = S_WAIT_REL;
          count_d  = count_q + 8'd1;
        end else if (gap_to) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_REL: begin
        if (fall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_PRESS1) || (state_q == S_GAP)) begin
      cnt_d = cnt_q + CW'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign busy         = busy_q;
  assign press_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_button_press_classifier: directed gestures plus random edge traffic   |
// | checked against a gesture-level reference model.         Revision: 1.0   |
// +--------------------------------------------------------------------------+
module tb_button_press_classifier;

  localparam int LONG_CYC = 20;
  localparam int GAP_CYC  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button_db = 1'b0;
  logic       button_rising = 1'b0;
  logic       button_falling = 1'b0;
  logic       short_press, double_press, long_press, busy;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  button_press_classifier #(
    .CLK_HZ (1000),
    .LONG_MS(20),
    .GAP_MS (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_db     (button_db),
    .button_rising (button_rising),
    .button_falling(button_falling),
    .short_press   (short_press),
    .double_press  (double_press),
    .long_press    (long_press),
    .busy          (busy),
    .press_count   (press_count)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Gesture-level reference: a gesture is open from an accepted press until it
  // is resolved and released; outcomes are decided from elapsed times.
  bit         m_active, m_held, m_decided;
  int         m_t_start, m_t_rel;
  logic       e_short, e_double, e_long, e_busy;
  logic [7:0] e_count;

  task automatic model_step();
    logic r, f;
    if (rst) begin
      m_active = 0; m_held = 0; m_decided = 0;
      e_short = 0; e_double = 0; e_long = 0; e_busy = 0; e_count = 8'd0;
    end else begin
      r = button_rising & ~button_falling;
      f = button_falling & ~button_rising;
      e_short = 0; e_double = 0; e_long = 0;
      if (!m_active) begin
        if (r) begin
          m_active = 1; m_held = 1; m_decided = 0;
          m_t_start = cyc; e_count = e_count + 8'd1;
        end
      end else if (m_decided) begin
        if (f) m_active = 0;
      end else if (m_held) begin
        if (f) begin
          m_held = 0; m_t_rel = cyc;
        end else if (cyc + 1 - m_t_start == LONG_CYC) begin
          e_long = 1; m_decided = 1;
        end
      end else begin
        if (r) begin
          e_double = 1; m_decided = 1; m_held = 1; e_count = e_count + 8'd1;
        end else if (cyc + 1 - m_t_rel == GAP_CYC) begin
          e_short = 1; m_active = 0;
        end
      end
      e_busy = m_active;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model short_press",  {7'd0, short_press},  {7'd0, e_short});
      chk("model double_press", {7'd0, double_press}, {7'd0, e_double});
      chk("model long_press",   {7'd0, long_press},   {7'd0, e_long});
      chk("model busy",         {7'd0, busy},         {7'd0, e_busy});
      chk("model press_count",  press_count,          e_count);
    end
  end

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive(input int c, input logic r, input logic f);
    go(c);
    button_rising  = r;
    button_falling = f;
    if (r & ~f) button_db = 1'b1;
    if (f & ~r) button_db = 1'b0;
    @(posedge clk); #1;
    button_rising  = 1'b0;
    button_falling = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " short"},  {7'd0, short_press},  8'd0);
    chk({tag, " double"}, {7'd0, double_press}, 8'd0);
    chk({tag, " long"},   {7'd0, long_press},   8'd0);
    chk({tag, " busy"},   {7'd0, busy},         8'd0);
    chk({tag, " count"},  press_count,          8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    button_rising = 1'b0; button_falling = 1'b0; button_db = 1'b0;
    #1;
    check_idle_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seg_p;
    logic r, f;

    // Short press
    do_reset();
    drive(100, 1, 0);
    go(101); chk("short busy@101", {7'd0, busy}, 8'd1);
    drive(105, 0, 1);
    go(114); chk("short busy@114", {7'd0, busy}, 8'd1);
    chk("short pulse@114", {7'd0, short_press}, 8'd0);
    go(115); chk("short pulse@115", {7'd0, short_press}, 8'd1);
    chk("short busy@115", {7'd0, busy}, 8'd0);
    chk("short count", press_count, 8'd1);

    // Double press
    do_reset();
    drive(100, 1, 0);
    drive(105, 0, 1);
    drive(110, 1, 0);
    go(111); chk("double pulse@111", {7'd0, double_press}, 8'd1);
    chk("double count", press_count, 8'd2);
    drive(112, 0, 1);
    go(113); chk("double busy@113", {7'd0, busy}, 8'd0);
    go(130); chk("double count end", press_count, 8'd2);

    // Long press, then release-beats-timeout boundary
    do_reset();
    drive(100, 1, 0);
    go(119); chk("long pulse@119", {7'd0, long_press}, 8'd0);
    go(120); chk("long pulse@120", {7'd0, long_press}, 8'd1);
    drive(150, 0, 1);
    go(151); chk("long busy@151", {7'd0, busy}, 8'd0);

    do_reset();
    drive(100, 1, 0);
    drive(119, 0, 1);
    go(120); chk("longbnd long@120", {7'd0, long_press}, 8'd0);
    chk("longbnd busy@120", {7'd0, busy}, 8'd1);
    go(129); chk("longbnd short@129", {7'd0, short_press}, 8'd1);

    // Gap boundary: second press on the last gap cycle, then one cycle late
    do_reset();
    drive(100, 1, 0);
    drive(105, 0, 1);
    drive(114, 1, 0);
    go(115); chk("gapbnd double@115", {7'd0, double_press}, 8'd1);
    drive(120, 0, 1);
    go(125);

    do_reset();
    drive(100, 1, 0);
    drive(105, 0, 1);
    go(115); chk("gaplate short@115", {7'd0, short_press}, 8'd1);
    drive(115, 1, 0);
    go(116); chk("gaplate busy@116", {7'd0, busy}, 8'd1);
    chk("gaplate count", press_count, 8'd2);
    drive(130, 0, 1);
    go(145);

    // Robustness: stray release, simultaneous edges, reset mid-press
    do_reset();
    drive(50, 0, 1);
    drive(60, 1, 1);
    go(61); chk("robust busy@61", {7'd0, busy}, 8'd0);
    chk("robust count@61", press_count, 8'd0);
    drive(100, 1, 0);
    drive(105, 1, 1);
    go(120); chk("robust long@120", {7'd0, long_press}, 8'd1);
    drive(125, 0, 1);
    drive(200, 1, 0);
    go(203);
    rst = 1'b1;
    #1;
    check_idle_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    go(40); chk("midrst busy", {7'd0, busy}, 8'd0);
    chk("midrst count", press_count, 8'd0);

    // Random edge traffic with occasional resets
    do_reset();
    seg_p = 8;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: seg_p = 3;
          1: seg_p = 8;
          default: seg_p = 30;
        endcase
      end
      r = ($urandom_range(0, seg_p - 1) == 0);
      f = ($urandom_range(0, seg_p - 1) == 0);
      button_rising  = r;
      button_falling = f;
      if (r & ~f) button_db = 1'b1;
      if (f & ~r) button_db = 1'b0;
      if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      else rst = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    button_rising  = 1'b0;
    button_falling = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
